// File: rtl/instr_mem_loadable.sv
// Loadable, byte-addressed, big-endian instruction memory with a byte-stream load port
// and a one-cycle registered fetch that flags reads outside the loaded image.
module instr_mem_loadable #(
  parameter int INSTR_WIDTH = 16,
  parameter int DEPTH_BYTES = 128,
  parameter int ADDR_WIDTH  = 16,
  parameter int CNT_WIDTH   = $clog2(DEPTH_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic                   load_last,
  input  logic [7:0]             load_byte,
  output logic                   load_ready,
  output logic                   load_done,
  output logic [CNT_WIDTH-1:0]   load_count,
  output logic                   fetch_ready,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic                   addr_fault
);

  localparam int BYTES = INSTR_WIDTH / 8;
  localparam int PTR_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int CMP_W = ((ADDR_WIDTH + 1 > CNT_WIDTH) ? ADDR_WIDTH + 1 : CNT_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state, state_next;

  logic [7:0]             mem [DEPTH_BYTES];
  logic [PTR_W-1:0]       ptr;
  logic                   accept;
  logic                   finish;
  logic                   fire;
  logic                   in_range;
  logic [INSTR_WIDTH-1:0] rd_word;

  assign load_ready  = (state == LOAD);
  assign fetch_ready = (state == RUN);
  assign accept      = (state == LOAD) && load_valid && !load_start;
  assign finish      = accept && (load_last || load_count == CNT_WIDTH'(DEPTH_BYTES - 1));
  assign fire        = (state == RUN) && fetch_req;

  // Range test is done wide enough that fetch_addr + BYTES can never wrap back into the image.
  assign in_range = (CMP_W'(fetch_addr) + CMP_W'(BYTES)) <= CMP_W'(load_count);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (load_start) state_next = LOAD;
      LOAD: if (!load_start && finish) state_next = RUN;
      RUN:  if (load_start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Lowest address lands in the most significant byte.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < BYTES; k++) begin
      rd_word[INSTR_WIDTH-1-8*k -: 8] = mem[PTR_W'(fetch_addr + ADDR_WIDTH'(k))];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[ptr] <= load_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      load_count  <= '0;
      load_done   <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end else begin
      load_done   <= finish;
      instr_valid <= fire;
      if (load_start) begin
        ptr        <= '0;
        load_count <= '0;
      end else if (accept) begin
        ptr        <= ptr + PTR_W'(1);
        load_count <= load_count + CNT_WIDTH'(1);
      end
      if (fire) begin
        instr      <= in_range ? rd_word : '0;
        addr_fault <= !in_range;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable: directed plus randomized loads and fetches
// compared against a byte-array image model; a second 32-bit instance covers wide words.
module tb_instr_mem_loadable;

  logic        clk;
  logic        reset;
  logic        load_start, load_valid, load_last;
  logic [7:0]  load_byte;
  logic        load_ready, load_done;
  logic [7:0]  load_count;
  logic        fetch_ready, fetch_req;
  logic [15:0] fetch_addr;
  logic [15:0] instr;
  logic        instr_valid, addr_fault;

  logic        w_load_start, w_load_valid, w_load_last;
  logic [7:0]  w_load_byte;
  logic        w_load_ready, w_load_done;
  logic [6:0]  w_load_count;
  logic        w_fetch_ready, w_fetch_req;
  logic [15:0] w_fetch_addr;
  logic [31:0] w_instr;
  logic        w_instr_valid, w_addr_fault;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0]  mdl_mem [128];
  int          mdl_count = 0;
  logic [7:0]  img_q [$];
  logic [7:0]  w_img [8];
  logic [15:0] last_instr;
  logic        last_fault;

  instr_mem_loadable dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
    .load_byte(load_byte), .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count), .fetch_ready(fetch_ready), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .instr(instr), .instr_valid(instr_valid),
    .addr_fault(addr_fault)
  );

  instr_mem_loadable #(.INSTR_WIDTH(32), .DEPTH_BYTES(64), .ADDR_WIDTH(16)) dut_wide (
    .clk(clk), .reset(reset),
    .load_start(w_load_start), .load_valid(w_load_valid), .load_last(w_load_last),
    .load_byte(w_load_byte), .load_ready(w_load_ready), .load_done(w_load_done),
    .load_count(w_load_count), .fetch_ready(w_fetch_ready), .fetch_req(w_fetch_req),
    .fetch_addr(w_fetch_addr), .instr(w_instr), .instr_valid(w_instr_valid),
    .addr_fault(w_addr_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic valid, input logic last,
                               input logic [7:0] b, input logic req, input logic [15:0] addr);
    load_start = start; load_valid = valid; load_last = last; load_byte = b;
    fetch_req = req; fetch_addr = addr;
    @(posedge clk);
    #1;
  endtask

  // The image model: a fetch is in range when every byte it needs lies below the loaded count.
  function automatic logic [15:0] modelInstr(input int addr);
    if (addr + 2 <= mdl_count) return {mdl_mem[addr], mdl_mem[addr+1]};
    return 16'h0000;
  endfunction

  function automatic logic [31:0] wideInstr(input int addr);
    if (addr + 4 <= 8) return {w_img[addr], w_img[addr+1], w_img[addr+2], w_img[addr+3]};
    return 32'h0;
  endfunction

  task automatic fetchCheck(input int addr);
    logic [15:0] exp;
    exp = modelInstr(addr);
    applyStimulus(0, 0, 0, 8'h00, 1, 16'(addr));
    checkOutput($sformatf("valid@%0h", addr), instr_valid, 1);
    checkOutput($sformatf("instr@%0h", addr), instr, exp);
    checkOutput($sformatf("fault@%0h", addr), addr_fault, (addr + 2 > mdl_count));
    last_instr = exp;
    last_fault = (addr + 2 > mdl_count);
  endtask

  task automatic idleCheck();
    applyStimulus(0, 0, 0, 8'h00, 0, 16'h0);
    checkOutput("idle_valid", instr_valid, 0);
    checkOutput("idle_instr_hold", instr, last_instr);
    checkOutput("idle_fault_hold", addr_fault, last_fault);
  endtask

  // Start cycle also presents a junk byte that must be dropped.
  task automatic loadImage(input bit use_last, input int max_gap);
    int n;
    n = img_q.size();
    applyStimulus(1, 1, 0, 8'hEE, 0, 16'h0);
    mdl_count = 0;
    checkOutput("start_count", load_count, 0);
    checkOutput("start_ready", load_ready, 1);
    checkOutput("start_fetch_ready", fetch_ready, 0);
    for (int i = 0; i < n; i++) begin
      bit fin;
      int gap;
      fin = (use_last && i == n - 1) || (i == 127);
      gap = $urandom_range(0, max_gap);
      for (int g = 0; g < gap; g++) begin
        applyStimulus(0, 0, 1, 8'h5A, 1, 16'h0);
        checkOutput("gap_count", load_count, i);
        checkOutput("gap_no_valid", instr_valid, 0);
      end
      applyStimulus(0, 1, use_last && i == n - 1, img_q[i], 0, 16'h0);
      mdl_mem[i] = img_q[i];
      mdl_count = i + 1;
      checkOutput("byte_count", load_count, i + 1);
      checkOutput("done_flag", load_done, fin);
      if (fin) break;
    end
    checkOutput("run_fetch_ready", fetch_ready, 1);
    checkOutput("run_load_ready", load_ready, 0);
    applyStimulus(0, 0, 0, 8'h00, 0, 16'h0);
    checkOutput("done_one_cycle", load_done, 0);
  endtask

  initial begin
    logic [15:0] exp;
    reset = 1'b1;
    w_load_start = 0; w_load_valid = 0; w_load_last = 0; w_load_byte = 0;
    w_fetch_req = 0; w_fetch_addr = 0;
    last_instr = 16'h0; last_fault = 1'b0;
    applyStimulus(0, 0, 0, 8'h00, 0, 16'h0);
    checkOutput("rst_count", load_count, 0);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_fault", addr_fault, 0);
    checkOutput("rst_done", load_done, 0);
    checkOutput("rst_ready", load_ready, 0);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 8'h00, 1, 16'h0);
      checkOutput("idle_fetch_ready", fetch_ready, 0);
      checkOutput("idle_fetch_valid", instr_valid, 0);
    end

    img_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    loadImage(1, 0);
    checkOutput("count4", load_count, 4);
    fetchCheck(0);
    checkOutput("plan_A1B2", instr, 16'hA1B2);
    fetchCheck(1);
    checkOutput("plan_B2C3", instr, 16'hB2C3);
    fetchCheck(3);
    checkOutput("plan_fault3", addr_fault, 1);
    fetchCheck(16'hFFFF);
    checkOutput("plan_faultFFFF", addr_fault, 1);
    idleCheck();

    img_q = '{};
    for (int i = 0; i < 128; i++) img_q.push_back(8'(i));
    loadImage(0, 0);
    checkOutput("count128", load_count, 128);
    fetchCheck(126);
    checkOutput("plan_7E7F", instr, 16'h7E7F);
    fetchCheck(127);
    fetchCheck(0);
    idleCheck();

    // Restart after two bytes, then a fresh two-byte image.
    applyStimulus(1, 0, 0, 8'h00, 0, 16'h0);
    applyStimulus(0, 1, 0, 8'h99, 0, 16'h0);
    applyStimulus(0, 1, 0, 8'h88, 0, 16'h0);
    checkOutput("partial_count", load_count, 2);
    img_q = '{8'h11, 8'h22};
    loadImage(1, 1);
    checkOutput("count2", load_count, 2);
    fetchCheck(0);
    checkOutput("plan_1122", instr, 16'h1122);
    fetchCheck(1);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 40);
      img_q = '{};
      for (int i = 0; i < n; i++) img_q.push_back(8'($urandom));
      loadImage(1, 2);
      for (int f = 0; f < 10; f++) fetchCheck($urandom_range(0, n + 1));
      fetchCheck(16'hFFFF);
      idleCheck();
    end

    // load_start together with a fetch in RUN: the fetch still completes.
    exp = modelInstr(0);
    applyStimulus(1, 0, 0, 8'h00, 1, 16'h0);
    checkOutput("restart_fetch_valid", instr_valid, 1);
    checkOutput("restart_fetch_instr", instr, exp);
    checkOutput("restart_fetch_ready", fetch_ready, 0);
    checkOutput("restart_count", load_count, 0);
    img_q = '{8'h5C, 8'h3D, 8'h7E};
    loadImage(1, 1);
    fetchCheck(1);

    // Asynchronous reset with a fetch result in flight.
    fetchCheck(0);
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", instr_valid, 0);
    checkOutput("arst_count", load_count, 0);
    checkOutput("arst_fetch_ready", fetch_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    mdl_count = 0;

    applyStimulus(1, 0, 0, 8'h00, 0, 16'h0);
    applyStimulus(0, 1, 0, 8'h01, 0, 16'h0);
    applyStimulus(0, 1, 0, 8'h02, 0, 16'h0);
    reset = 1'b1;
    #1;
    checkOutput("arst_load_ready", load_ready, 0);
    checkOutput("arst_load_count", load_count, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 8'h00, 1, 16'h0);
    checkOutput("post_rst_no_fetch", instr_valid, 0);

    // Wide instance: 32-bit words over a 64-byte store.
    w_load_start = 1;
    applyStimulus(0, 0, 0, 8'h00, 0, 16'h0);
    w_load_start = 0;
    for (int i = 0; i < 8; i++) begin
      w_img[i] = 8'(i + 1);
      w_load_valid = 1; w_load_byte = 8'(i + 1); w_load_last = (i == 7);
      applyStimulus(0, 0, 0, 8'h00, 0, 16'h0);
    end
    w_load_valid = 0; w_load_last = 0;
    checkOutput("w_done", w_load_done, 1);
    checkOutput("w_count", w_load_count, 8);
    for (int a = 0; a < 7; a++) begin
      w_fetch_req = 1; w_fetch_addr = 16'(a);
      applyStimulus(0, 0, 0, 8'h00, 0, 16'h0);
      checkOutput($sformatf("w_valid@%0d", a), w_instr_valid, 1);
      checkOutput($sformatf("w_instr@%0d", a), w_instr, wideInstr(a));
      checkOutput($sformatf("w_fault@%0d", a), w_addr_fault, (a + 4 > 8));
      if (a == 0) checkOutput("w_plan_01020304", w_instr, 32'h01020304);
      if (a == 4) checkOutput("w_plan_05060708", w_instr, 32'h05060708);
    end
    w_fetch_req = 0;
    applyStimulus(0, 0, 0, 8'h00, 0, 16'h0);
    checkOutput("w_idle_valid", w_instr_valid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, loadable instruction memory for the single-cycle processor. It is byte-addressed and big-endian, like the current fixed 16-bit instruction memory. Contents are written at run time through a byte-stream load port with a valid/ready handshake. Instructions are returned with one cycle of registered latency, and fetches that fall outside the loaded image are flagged. It sits between the boot/UART loader and the PC/fetch stage.

## Interface
- INSTR_WIDTH, 16: instruction width in bits; must be a multiple of 8; BYTES = INSTR_WIDTH/8
- DEPTH_BYTES, 128: storage size in bytes, ≥ BYTES
- ADDR_WIDTH, 16: fetch address width
- CNT_WIDTH, $clog2(DEPTH_BYTES+1): width of the loaded-byte counter

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- load_start  input  1  begin a new image load
- load_valid  input  1  load_byte is valid this cycle
- load_last  input  1  qualifies load_byte as the final byte of the image
- load_byte  input  8  image byte
- load_ready  output  1  block accepts a byte this cycle
- load_done  output  1  one-cycle pulse: image complete
- load_count  output  CNT_WIDTH  number of bytes in the current image
- fetch_ready  output  1  fetches are accepted (state RUN)
- fetch_req  input  1  fetch request
- fetch_addr  input  ADDR_WIDTH  byte address of the instruction
- instr  output  INSTR_WIDTH  fetched instruction
- instr_valid  output  1  instr/addr_fault valid this cycle
- addr_fault  output  1  fetch was outside the loaded image

## Operation
- States: IDLE, LOAD, RUN. Reset forces IDLE.
- Reset values: load_count=0, instr=0, instr_valid=0, addr_fault=0, load_done=0. The write pointer is cleared to 0. Storage is not cleared.
- IDLE:
  - load_start → LOAD with pointer=0 and load_count=0.
  - Fetches are ignored.
- LOAD:
  - load_ready=1.
  - A byte is accepted when load_valid=1; it is written to mem[pointer], then pointer++ and load_count++.
  - Leaves for RUN when the accepted byte has load_last=1, or when it is byte number DEPTH_BYTES (automatic finish, load_last ignored).
  - load_start in LOAD restarts the load: pointer=0, load_count=0, and any byte presented that cycle is dropped.
- RUN:
  - fetch_ready=1; load_ready=0.
  - load_start → LOAD; the image is discarded because load_count resets to 0.
- Fetch (RUN only, fetch_req=1):
  - In-range condition: fetch_addr + BYTES ≤ load_count, computed at ADDR_WIDTH+1 bits with no wrap-around.
  - In range: instr = {mem[a], mem[a+1], …, mem[a+BYTES-1]}, with the lowest address in the MSBs; addr_fault=0.
  - Out of range: instr=0, addr_fault=1.
  - Odd or unaligned addresses are legal.
- A fetch_req while fetch_ready=0 produces no response; instr_valid stays 0.
- Storage is a single write port plus BYTES read ports. Only LOAD writes and only RUN reads, so the two never collide.

## Timing
- load_ready and fetch_ready are combinational from the registered state only.
- A byte accepted at edge N is readable by a fetch issued in RUN at edge ≥ N+1.
- The final byte accepted at edge N gives:
  - state=RUN after edge N
  - load_done=1 for the cycle following edge N only
  - fetch_ready=1 from the same cycle
- Fetch latency is 1 cycle:
  - Request sampled at edge N → instr, addr_fault and instr_valid=1 during cycle N+1.
  - With no request at edge N, instr_valid=0 in cycle N+1 and instr/addr_fault hold their last values.
- Back-to-back fetches give one result per cycle.
- Asynchronous reset mid-load or mid-fetch:
  - immediate return to IDLE
  - pending instr_valid dropped
  - load_count=0
- load_start accepted in RUN at edge N: fetch_ready=0 from cycle N+1, and a fetch sampled at edge N still completes in cycle N+1.

## Test plan
- Reset, load 4 bytes A1 B2 C3 D4 (last on D4), fetch 0 → load_done pulses once, load_count=4; cycle later instr=A1B2, instr_valid=1, addr_fault=0.
- Same image, fetch addr 1 → instr=B2C3. Fetch addr 3 → instr=0000, addr_fault=1. Fetch 0xFFFF → addr_fault=1, with no wrap to byte 0.
- Fetch while IDLE and during LOAD → fetch_ready=0, instr_valid never asserts. Hold load_valid low for 3 cycles mid-load → no extra bytes written and load_count unchanged.
- Stream 128 bytes 0x00…0x7F with no load_last → automatic RUN after byte 128, load_count=128. Fetch 126 → 7E7F; fetch 127 → fault.
- load_start after 2 bytes of a load, then new image 11 22 → load_count=2, fetch 0 → 1122. Assert reset mid-load → IDLE, load_count=0, load_ready=0 immediately.
- INSTR_WIDTH=32, DEPTH_BYTES=64, load 8 bytes 01..08 → fetch 0 → 01020304; fetch 4 → 05060708; fetch 5 → fault.
